// File: rtl/psddivide_pkg.sv
// rtl/psddivide_pkg.sv - shared FSM encoding and sizing constants for the divider arbiter.
package psddivide_pkg;
    localparam int DIV_CYCLES_DEF = 32;
    localparam int N_REQ          = 2;
    localparam int OP_W           = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_RUN,
        S_STOP,
        S_LOAD,
        S_RESP
    } state_t;
endpackage

// File: rtl/psddivide.sv
// rtl/psddivide.sv - restoring divider, one quotient bit per cycle after start; outputs load on stop.
module psddivide
    import psddivide_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    input  logic            i_start,
    input  logic            i_stop,
    input  logic [OP_W-1:0] i_dividend,
    input  logic [OP_W-1:0] i_divisor,
    output logic [OP_W-1:0] o_quotient,
    output logic [OP_W-1:0] o_rest
);
    logic [OP_W-1:0] r_q;
    logic [OP_W-1:0] r_r;
    logic [OP_W-1:0] r_d;
    logic [5:0]      r_cnt;
    logic [OP_W:0]   w_sh;
    logic [OP_W:0]   w_diff;

    assign w_sh   = {r_r, r_q[OP_W-1]};
    assign w_diff = w_sh - {1'b0, r_d};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q        <= '0;
            r_r        <= '0;
            r_d        <= '0;
            r_cnt      <= '0;
            o_quotient <= '0;
            o_rest     <= '0;
        end else if (i_start) begin
            r_q   <= i_dividend;
            r_r   <= '0;
            r_d   <= i_divisor;
            r_cnt <= 6'd32;
        end else if (i_stop) begin
            o_quotient <= r_q;
            o_rest     <= r_r;
        end else if (r_cnt != 6'd0) begin
            // A zero divisor always subtracts, giving all-ones and the dividend as rest.
            if (w_sh >= {1'b0, r_d}) begin
                r_r <= w_diff[OP_W-1:0];
                r_q <= {r_q[OP_W-2:0], 1'b1};
            end else begin
                r_r <= w_sh[OP_W-1:0];
                r_q <= {r_q[OP_W-2:0], 1'b0};
            end
            r_cnt <= r_cnt - 6'd1;
        end
    end
endmodule

// File: rtl/psddivide_rr2.sv
// rtl/psddivide_rr2.sv - two-way round-robin grant; grants only while i_accept allows a new request.
module psddivide_rr2
    import psddivide_pkg::*;
(
    input  logic [N_REQ-1:0] i_valid,
    input  logic             i_last,
    input  logic             i_accept,
    output logic [N_REQ-1:0] o_grant
);
    always_comb begin
        o_grant = '0;
        if (i_accept) begin
            // On contention the requester that was not served last wins.
            if (i_valid == 2'b11) begin
                o_grant = i_last ? 2'b01 : 2'b10;
            end else begin
                o_grant = i_valid;
            end
        end
    end
endmodule

// File: rtl/psddivide_arb.sv
// rtl/psddivide_arb.sv - two-requester front end sequencing one shared divider with fixed latency.
// Optional PSDDIVIDE_ARB_DIVZERO_EN answers divisor-0 requests directly without using the divider.
module psddivide_arb
    import psddivide_pkg::*;
#(
    parameter int DIV_CYCLES = DIV_CYCLES_DEF
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [63:0] req_dividend,
    input  logic [63:0] req_divisor,
    output logic [1:0]  resp_valid,
    input  logic [1:0]  resp_ready,
    output logic [31:0] resp_quotient,
    output logic [31:0] resp_rest,
    output logic        resp_divzero,
    output logic        div_start,
    output logic        div_stop,
    output logic [31:0] div_dividend,
    output logic [31:0] div_divisor,
    input  logic [31:0] div_quotient,
    input  logic [31:0] div_rest
);
    localparam int CNT_W = $clog2(DIV_CYCLES) + 1;

    state_t          r_state;
    logic [CNT_W-1:0] r_cnt;
    logic            r_last;
    logic            r_owner;
    logic [1:0]      r_resp_valid;
    logic [OP_W-1:0] r_quotient;
    logic [OP_W-1:0] r_rest;
    logic            r_div_start;
    logic            r_div_stop;
    logic [OP_W-1:0] r_dividend;
    logic [OP_W-1:0] r_divisor;

    logic [1:0]      w_grant;
    logic            w_accept;
    logic            w_idx;
    logic [OP_W-1:0] w_dvd;
    logic [OP_W-1:0] w_dvs;
    logic            w_resp_done;

    psddivide_rr2 u_rr2 (
        .i_valid  (req_valid),
        .i_last   (r_last),
        .i_accept (r_state == S_IDLE),
        .o_grant  (w_grant)
    );

    assign w_accept    = |(req_valid & w_grant);
    assign w_idx       = w_grant[1];
    assign w_dvd       = w_idx ? req_dividend[63:32] : req_dividend[31:0];
    assign w_dvs       = w_idx ? req_divisor[63:32]  : req_divisor[31:0];
    // resp_valid is one-hot on the owner, so non-owner ready bits drop out here.
    assign w_resp_done = |(resp_ready & r_resp_valid);

    assign req_ready     = w_grant;
    assign resp_valid    = r_resp_valid;
    assign resp_quotient = r_quotient;
    assign resp_rest     = r_rest;
    assign div_start     = r_div_start;
    assign div_stop      = r_div_stop;
    assign div_dividend  = r_dividend;
    assign div_divisor   = r_divisor;

`ifdef PSDDIVIDE_ARB_DIVZERO_EN
    logic r_divzero;
    assign resp_divzero = r_divzero;
`else
    assign resp_divzero = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_last       <= 1'b1;
            r_owner      <= 1'b0;
            r_resp_valid <= '0;
            r_quotient   <= '0;
            r_rest       <= '0;
            r_div_start  <= 1'b0;
            r_div_stop   <= 1'b0;
            r_dividend   <= '0;
            r_divisor    <= '0;
`ifdef PSDDIVIDE_ARB_DIVZERO_EN
            r_divzero    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_last     <= w_idx;
                        r_owner    <= w_idx;
                        r_dividend <= w_dvd;
                        r_divisor  <= w_dvs;
`ifdef PSDDIVIDE_ARB_DIVZERO_EN
                        if (w_dvs == '0) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= w_idx ? 2'b10 : 2'b01;
                            r_quotient   <= '1;
                            r_rest       <= w_dvd;
                            r_divzero    <= 1'b1;
                        end else begin
                            r_state     <= S_START;
                            r_div_start <= 1'b1;
                        end
`else
                        r_state     <= S_START;
                        r_div_start <= 1'b1;
`endif
                    end
                end
                S_START: begin
                    r_div_start <= 1'b0;
                    r_cnt       <= '0;
                    r_state     <= S_RUN;
                end
                S_RUN: begin
                    if (r_cnt == CNT_W'(DIV_CYCLES - 1)) begin
                        r_div_stop <= 1'b1;
                        r_state    <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    r_div_stop <= 1'b0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    r_quotient   <= div_quotient;
                    r_rest       <= div_rest;
                    r_resp_valid <= r_owner ? 2'b10 : 2'b01;
`ifdef PSDDIVIDE_ARB_DIVZERO_EN
                    r_divzero    <= 1'b0;
`endif
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (w_resp_done) begin
                        r_resp_valid <= '0;
                        r_state      <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_psddivide_arb.sv
// tb/tb_psddivide_arb.sv - directed scoreboard bench for psddivide_arb driving psddivide.
module tb_psddivide_arb;
    localparam int DIV_CYCLES = 32;
    localparam int LAT        = DIV_CYCLES + 3;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [63:0] req_dividend;
    logic [63:0] req_divisor;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_ready;
    logic [31:0] resp_quotient;
    logic [31:0] resp_rest;
    logic        resp_divzero;
    logic        div_start;
    logic        div_stop;
    logic [31:0] div_dividend;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_rest;

    psddivide_arb #(.DIV_CYCLES(DIV_CYCLES)) dut (
        .clock         (clock),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_dividend  (req_dividend),
        .req_divisor   (req_divisor),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_quotient (resp_quotient),
        .resp_rest     (resp_rest),
        .resp_divzero  (resp_divzero),
        .div_start     (div_start),
        .div_stop      (div_stop),
        .div_dividend  (div_dividend),
        .div_divisor   (div_divisor),
        .div_quotient  (div_quotient),
        .div_rest      (div_rest)
    );

    psddivide u_div (
        .clock      (clock),
        .reset      (reset),
        .i_start    (div_start),
        .i_stop     (div_stop),
        .i_dividend (div_dividend),
        .i_divisor  (div_divisor),
        .o_quotient (div_quotient),
        .o_rest     (div_rest)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          owner;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          lat;
        int          acc;
        int          nst;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   n_start = 0;
    int   n_stop = 0;
    int   n_both = 0;
    int   start_cyc = 0;
    int   stop_cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (div_start) begin
            n_start++;
            start_cyc = cyc;
        end
        if (div_stop) begin
            n_stop++;
            stop_cyc = cyc;
        end
        if (div_start && div_stop) n_both++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh(input int i);
        return (i != 0) ? 2'b10 : 2'b01;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int idx, input logic [31:0] dvd, input logic [31:0] dvs);
        req_dividend[idx*32 +: 32] = dvd;
        req_divisor[idx*32 +: 32]  = dvs;
    endtask

    // Waits for the accept (sampled just after a falling edge) and queues the expected response.
    task automatic wait_accept(output int idx, output int acc);
        bit          got;
        exp_t        e;
        logic [31:0] dvd;
        logic [31:0] dvs;
        got = 0;
        idx = 0;
        acc = 0;
        #1;
        for (int k = 0; k < 200 && !got; k++) begin
            if ((req_valid & req_ready) != 2'b00) got = 1;
            else begin
                @(negedge clock);
                #1;
            end
        end
        chk("accept_seen", got, 1);
        if (got) begin
            idx   = req_ready[1] ? 1 : 0;
            acc   = cyc + 1;
            dvd   = req_dividend[idx*32 +: 32];
            dvs   = req_divisor[idx*32 +: 32];
            e.owner = idx;
            e.q     = (dvs == 0) ? 32'hffffffff : dvd / dvs;
            e.r     = (dvs == 0) ? dvd : dvd % dvs;
            e.dz    = 1'b0;
            e.lat   = LAT;
`ifdef PSDDIVIDE_ARB_DIVZERO_EN
            if (dvs == 0) begin
                e.dz  = 1'b1;
                e.lat = 1;
            end
`endif
            e.acc = acc;
            e.nst = n_start;
            sb.push_back(e);
        end
    endtask

    task automatic handle_resp(input int hold, output int hs);
        bit   got;
        exp_t e;
        int   nst;
        got = 0;
        hs  = cyc;
        for (int k = 0; k < 300 && !got; k++) begin
            @(negedge clock);
            if (resp_valid != 2'b00) got = 1;
        end
        chk("resp_seen", got, 1);
        if (!got) return;
        chk("scoreboard_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk("latency", cyc - e.acc, e.lat);
        chk("resp_valid", resp_valid, oh(e.owner));
        chk("quotient", resp_quotient, e.q);
        chk("rest", resp_rest, e.r);
        chk("divzero", resp_divzero, e.dz);
        if (e.lat == LAT) begin
            chk("start_count", n_start - e.nst, 1);
            chk("start_cycle", start_cyc, e.acc);
            chk("stop_gap", stop_cyc - start_cyc, DIV_CYCLES + 1);
        end else begin
            chk("no_start", n_start - e.nst, 0);
        end
        for (int k = 0; k < hold; k++) begin
            resp_ready = ~oh(e.owner);
            nst = n_start;
            @(negedge clock);
            chk("hold_outputs", {resp_valid, resp_quotient, resp_rest, resp_divzero, req_ready},
                {oh(e.owner), e.q, e.r, e.dz, 2'b00});
            chk("hold_no_start", n_start - nst, 0);
        end
        resp_ready = oh(e.owner);
        hs = cyc + 1;
        @(negedge clock);
        resp_ready = 2'b00;
        chk("resp_dropped", resp_valid, 2'b00);
    endtask

    initial begin
        int idx;
        int acc;
        int hs;
        int prev;
        int nstop;
        bit any;
        logic [31:0] rd;
        logic [31:0] rv;

        reset        = 1'b1;
        req_valid    = 2'b00;
        req_dividend = '0;
        req_divisor  = '0;
        resp_ready   = 2'b00;
        repeat (3) @(negedge clock);
        reset = 1'b0;
        chk("reset_outputs", {req_ready, resp_valid, resp_quotient, resp_rest, resp_divzero,
            div_start, div_stop, div_dividend, div_divisor}, '0);

        // Contention right after reset: req0 has priority, req1 follows the handshake.
        set_req(0, 32'hffffffff, 32'h00000001);
        set_req(1, 32'h11111111, 32'h11111111);
        req_valid = 2'b11;
        wait_accept(idx, acc);
        chk("cont_first_owner", idx, 0);
        @(negedge clock);
        req_valid = 2'b10;
        handle_resp(0, hs);
        wait_accept(idx, acc);
        chk("cont_second_owner", idx, 1);
        chk("cont_second_accept", acc, hs + 1);
        @(negedge clock);
        req_valid = 2'b00;
        handle_resp(0, hs);

        // Single request with the reference operands.
        set_req(0, 32'h12345678, 32'h0beefeba);
        req_valid = 2'b01;
        wait_accept(idx, acc);
        chk("single_owner", idx, 0);
        chk("single_model_q", sb[0].q, 32'h00000001);
        chk("single_model_r", sb[0].r, 32'h064557be);
        @(negedge clock);
        req_valid = 2'b00;
        handle_resp(0, hs);

        // Back-pressure on req1 while req0 waits.
        set_req(1, 32'h9abcdef0, 32'h00001234);
        req_valid = 2'b10;
        wait_accept(idx, acc);
        chk("bp_owner", idx, 1);
        @(negedge clock);
        set_req(0, 32'h0000ffff, 32'h00000010);
        req_valid = 2'b01;
        handle_resp(10, hs);
        wait_accept(idx, acc);
        chk("bp_next_owner", idx, 0);
        chk("bp_next_accept", acc, hs + 1);
        @(negedge clock);
        req_valid = 2'b00;
        handle_resp(0, hs);

        // Reset ten cycles into RUN discards the request.
        set_req(0, 32'hdeadbeef, 32'h0000abcd);
        req_valid = 2'b01;
        wait_accept(idx, acc);
        @(negedge clock);
        req_valid = 2'b00;
        repeat (11) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_outputs", {req_ready, resp_valid, resp_quotient, resp_rest, resp_divzero,
            div_start, div_stop, div_dividend, div_divisor}, '0);
        if (sb.size() != 0) void'(sb.pop_back());
        nstop = n_stop;
        any = 0;
        repeat (40) begin
            @(negedge clock);
            if (resp_valid != 2'b00) any = 1;
        end
        chk("abort_no_resp", any, 0);
        chk("abort_no_stop", n_stop - nstop, 0);
        set_req(1, 32'h87654321, 32'h00000007);
        req_valid = 2'b10;
        wait_accept(idx, acc);
        chk("post_abort_owner", idx, 1);
        @(negedge clock);
        req_valid = 2'b00;
        handle_resp(0, hs);

        // Divide by zero.
        set_req(0, 32'h00000001, 32'h00000000);
        req_valid = 2'b01;
        wait_accept(idx, acc);
        chk("dz_owner", idx, 0);
        @(negedge clock);
        req_valid = 2'b00;
        handle_resp(0, hs);

        // Fairness with both requesters continuously valid.
        prev = 0;
        for (int i = 0; i < 2; i++) begin
            rd = $urandom;
            rv = $urandom >> $urandom_range(0, 31);
            if (rv == 0) rv = 32'd1;
            set_req(i, rd, rv);
        end
        req_valid = 2'b11;
        for (int n = 0; n < 8; n++) begin
            wait_accept(idx, acc);
            chk("fair_grant", idx, prev ^ 1);
            prev = idx;
            @(negedge clock);
            rd = $urandom;
            rv = $urandom >> $urandom_range(0, 31);
            if (rv == 0) rv = 32'd1;
            set_req(idx, rd, rv);
            handle_resp(0, hs);
        end
        req_valid = 2'b00;
        repeat (2) @(negedge clock);

        chk("start_stop_exclusive", n_both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
